// File: rtl/spi_s_pkg.sv
// Shared types and constants for the SPI byte slave.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package spi_s_pkg;

  localparam int BYTE_W = 8;
  // Counter must hold 0..BYTE_W inclusive.
  localparam int BCNT_W = $clog2(BYTE_W + 1);

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    SHIFT,
    BYTE_DONE,
    LOAD_NEXT
  } state_t;

  // Bit of a TX byte that goes out in serial slot idx (slot 0 is sent first).
  function automatic logic tx_bit(input logic [BYTE_W-1:0] b,
                                  input logic [BCNT_W-1:0] idx,
                                  input logic              msb_first);
    logic [BYTE_W-1:0] t;
    t = msb_first ? (b << idx) : (b >> idx);
    return msb_first ? t[BYTE_W-1] : t[0];
  endfunction

endpackage

// File: rtl/spi_s_sync.sv
// N-stage pin synchronizer followed by a single edge-detect register.
// Latency: level after N clk, rise/fall strobes valid in the same cycle as the new level.
// Backpressure: none; free-running sampler.
module spi_s_sync #(
  parameter int N = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic i_pin,
  output logic o_level,
  output logic o_rise,
  output logic o_fall
);

  logic [N-1:0] r_sync;
  logic         r_prev;

  // Resynchronize the asynchronous pin and remember the previous level for edge detection.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync <= '0;
      r_prev <= 1'b0;
    end else begin
      r_sync <= {r_sync[N-2:0], i_pin};
      r_prev <= r_sync[N-1];
    end
  end

  assign o_level = r_sync[N-1];
  assign o_rise  = r_sync[N-1] & ~r_prev;
  assign o_fall  = ~r_sync[N-1] & r_prev;

endmodule

// File: rtl/spi_slave_byte_if.sv
// SPI mode-0 slave: oversampled pins, MOSI bytes out on a valid/ready stream, TX bytes onto MISO.
// Latency: pin edge acted on SYNC_STAGES+1 clk later; a byte is delivered 2 clk after the 8th synced scl rise.
// Backpressure: RX byte held until rx_ready (a further byte is dropped with rx_overrun); tx_ready low while holding full.
module spi_slave_byte_if
  import spi_s_pkg::*;
#(
  parameter int                SYNC_STAGES  = 2,
  parameter bit                MSB_FIRST    = 1'b1,
  parameter logic [BYTE_W-1:0] TX_IDLE_BYTE = 8'hFF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              scl,
  input  logic              cs,
  input  logic              mosi,
  output logic              miso,
  output logic              miso_oe,
  output logic [BYTE_W-1:0] rx_data,
  output logic              rx_valid,
  input  logic              rx_ready,
  input  logic [BYTE_W-1:0] tx_data,
  input  logic              tx_valid,
  output logic              tx_ready,
  output logic              rx_overrun,
  output logic              tx_underrun,
  output logic              frame_err
);

  localparam logic [BCNT_W-1:0] LAST_BIT = BCNT_W'(BYTE_W - 1);
  localparam logic [BCNT_W-1:0] FULL_CNT = BCNT_W'(BYTE_W);

  logic w_scl_lvl_unused, w_scl_rise, w_scl_fall;
  logic w_cs_lvl, w_cs_rise, w_cs_fall;
  logic w_mosi_lvl, w_mosi_rise_unused, w_mosi_fall_unused;

  state_t            r_state, w_state_nxt;
  logic [BCNT_W-1:0] r_bit_cnt;
  logic [BYTE_W-1:0] r_shift_rx, r_shift_tx, r_tx_hold, r_rx_data;
  logic              r_tx_full, r_rx_valid, r_miso, r_miso_oe, r_cs_seen_hi;
  logic              r_rx_overrun, r_tx_underrun, r_frame_err;

  logic              w_load, w_rx_shift, w_tx_next, w_deliver, w_ferr, w_tx_wr, w_mid_byte;
  logic [BYTE_W-1:0] w_load_byte;

  spi_s_sync #(.N(SYNC_STAGES)) u_sync_scl (
    .clk(clk), .rst(rst), .i_pin(scl),
    .o_level(w_scl_lvl_unused), .o_rise(w_scl_rise), .o_fall(w_scl_fall)
  );

  // cs syncs to 0 in reset, so a cs already low when reset releases produces no fall edge.
  spi_s_sync #(.N(SYNC_STAGES)) u_sync_cs (
    .clk(clk), .rst(rst), .i_pin(cs),
    .o_level(w_cs_lvl), .o_rise(w_cs_rise), .o_fall(w_cs_fall)
  );

  spi_s_sync #(.N(SYNC_STAGES)) u_sync_mosi (
    .clk(clk), .rst(rst), .i_pin(mosi),
    .o_level(w_mosi_lvl), .o_rise(w_mosi_rise_unused), .o_fall(w_mosi_fall_unused)
  );

  assign w_mid_byte  = (r_bit_cnt != '0) && (r_bit_cnt < FULL_CNT);
  assign w_load_byte = r_tx_full ? r_tx_hold : TX_IDLE_BYTE;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_nxt;
  end

  // Next state and one-cycle action strobes; cs rising aborts any active frame first.
  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    w_rx_shift  = 1'b0;
    w_tx_next   = 1'b0;
    w_deliver   = 1'b0;
    w_ferr      = 1'b0;
    if (r_state != IDLE && w_cs_rise) begin
      w_state_nxt = IDLE;
      w_ferr      = w_mid_byte;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_cs_fall) w_state_nxt = LOAD;
        end
        LOAD: begin
          w_load      = 1'b1;
          w_state_nxt = SHIFT;
        end
        SHIFT: begin
          if (w_scl_rise) begin
            w_rx_shift = 1'b1;
            if (r_bit_cnt == LAST_BIT) w_state_nxt = BYTE_DONE;
          end else if (w_scl_fall && w_mid_byte) begin
            w_tx_next = 1'b1;
          end
        end
        BYTE_DONE: begin
          w_deliver   = 1'b1;
          w_state_nxt = LOAD_NEXT;
        end
        LOAD_NEXT: begin
          if (w_scl_fall) begin
            w_load      = 1'b1;
            w_state_nxt = SHIFT;
          end
        end
        default: w_state_nxt = IDLE;
      endcase
    end
  end

  // Bit counter and RX shift register; a partial byte is discarded by clearing the count on abort.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_bit_cnt  <= '0;
      r_shift_rx <= '0;
    end else begin
      if (w_state_nxt == IDLE || w_deliver) r_bit_cnt <= '0;
      else if (w_rx_shift)                  r_bit_cnt <= r_bit_cnt + 1'b1;
      if (w_rx_shift)
        r_shift_rx <= MSB_FIRST ? {r_shift_rx[BYTE_W-2:0], w_mosi_lvl}
                                : {w_mosi_lvl, r_shift_rx[BYTE_W-1:1]};
    end
  end

  // TX holding register and serializer; a same-cycle write lands in holding after the old value is loaded.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_tx_hold     <= '0;
      r_tx_full     <= 1'b0;
      r_shift_tx    <= '0;
      r_tx_underrun <= 1'b0;
    end else begin
      r_tx_underrun <= w_load & ~r_tx_full;
      if (w_load) r_shift_tx <= w_load_byte;
      if (w_tx_wr) begin
        r_tx_hold <= tx_data;
        r_tx_full <= 1'b1;
      end else if (w_load) begin
        r_tx_full <= 1'b0;
      end
    end
  end

  // MISO drive: first bit on load, later bits on scl falling; holds its last value between frames.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_miso       <= 1'b0;
      r_miso_oe    <= 1'b0;
      r_cs_seen_hi <= 1'b0;
    end else begin
      if (w_load)         r_miso <= tx_bit(w_load_byte, '0, MSB_FIRST);
      else if (w_tx_next) r_miso <= tx_bit(r_shift_tx, r_bit_cnt, MSB_FIRST);
      if (w_cs_lvl) r_cs_seen_hi <= 1'b1;
      r_miso_oe <= ~w_cs_lvl & r_cs_seen_hi;
    end
  end

  // RX output register with overrun detection, plus the frame error pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rx_data    <= '0;
      r_rx_valid   <= 1'b0;
      r_rx_overrun <= 1'b0;
      r_frame_err  <= 1'b0;
    end else begin
      r_rx_overrun <= 1'b0;
      r_frame_err  <= w_ferr;
      if (w_deliver) begin
        if (!r_rx_valid || rx_ready) begin
          r_rx_data  <= r_shift_rx;
          r_rx_valid <= 1'b1;
        end else begin
          r_rx_overrun <= 1'b1;
        end
      end else if (r_rx_valid && rx_ready) begin
        r_rx_valid <= 1'b0;
      end
    end
  end

  assign w_tx_wr     = tx_valid & tx_ready;
  assign tx_ready    = ~r_tx_full | w_load;
  assign miso        = r_miso;
  assign miso_oe     = r_miso_oe;
  assign rx_data     = r_rx_data;
  assign rx_valid    = r_rx_valid;
  assign rx_overrun  = r_rx_overrun;
  assign tx_underrun = r_tx_underrun;
  assign frame_err   = r_frame_err;

endmodule

// File: tb/tb_spi_slave_byte_if.sv
// Bench for spi_slave_byte_if: directed SPI master with scoreboarded RX stream and MISO bytes.
// Latency: n/a.
// Backpressure: rx_ready and tx_valid driven directly by the stimulus.
module tb_spi_slave_byte_if;

  logic       clk = 1'b0;
  logic       rst, scl, mosi, cs0, cs1;
  logic       miso0, miso1, miso_oe0, miso_oe1;
  logic [7:0] rx_data0, rx_data1, tx_data0, tx_data1;
  logic       rx_valid0, rx_valid1, rx_ready0, rx_ready1;
  logic       tx_valid0, tx_valid1, tx_ready0, tx_ready1;
  logic       rx_overrun0, rx_overrun1, tx_underrun0, tx_underrun1, frame_err0, frame_err1;

  int checks = 0;
  int failures = 0;
  int n_ovr0 = 0, n_und0 = 0, n_ferr0 = 0;
  int n_ovr1 = 0, n_und1 = 0, n_ferr1 = 0;

  logic [7:0] exp_rx0[$], exp_rx1[$], exp_miso0[$], exp_miso1[$];
  logic [7:0] sh0 = '0, sh1 = '0;
  int         bc0 = 0, bc1 = 0;
  logic       scl_q = 1'b0;

  always #5 clk = ~clk;

  spi_slave_byte_if dut0 (
    .clk(clk), .rst(rst), .scl(scl), .cs(cs0), .mosi(mosi),
    .miso(miso0), .miso_oe(miso_oe0),
    .rx_data(rx_data0), .rx_valid(rx_valid0), .rx_ready(rx_ready0),
    .tx_data(tx_data0), .tx_valid(tx_valid0), .tx_ready(tx_ready0),
    .rx_overrun(rx_overrun0), .tx_underrun(tx_underrun0), .frame_err(frame_err0)
  );

  spi_slave_byte_if #(.MSB_FIRST(1'b0)) dut1 (
    .clk(clk), .rst(rst), .scl(scl), .cs(cs1), .mosi(mosi),
    .miso(miso1), .miso_oe(miso_oe1),
    .rx_data(rx_data1), .rx_valid(rx_valid1), .rx_ready(rx_ready1),
    .tx_data(tx_data1), .tx_valid(tx_valid1), .tx_ready(tx_ready1),
    .rx_overrun(rx_overrun1), .tx_underrun(tx_underrun1), .frame_err(frame_err1)
  );

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", name, got, exp);
    end
  endtask

  task automatic pop_chk(input string name, inout logic [7:0] q[$], input logic [7:0] got);
    if (q.size() == 0) begin
      checks++;
      failures++;
      $display("FAIL %s unexpected byte got=0x%0h exp=none", name, got);
    end else begin
      chk(name, got, q.pop_front());
    end
  endtask

  // Monitor: pulse counters, RX handshakes, and MISO bytes captured on scl rising while cs is low.
  always @(negedge clk) begin
    if (rx_overrun0)  n_ovr0++;
    if (tx_underrun0) n_und0++;
    if (frame_err0)   n_ferr0++;
    if (rx_overrun1)  n_ovr1++;
    if (tx_underrun1) n_und1++;
    if (frame_err1)   n_ferr1++;
    if (rx_valid0 && rx_ready0) pop_chk("rx0", exp_rx0, rx_data0);
    if (rx_valid1 && rx_ready1) pop_chk("rx1", exp_rx1, rx_data1);
    if (cs0) bc0 = 0;
    else if (scl && !scl_q) begin
      sh0 = {sh0[6:0], miso0};
      bc0++;
      if (bc0 == 8) begin pop_chk("miso0", exp_miso0, sh0); bc0 = 0; end
    end
    if (cs1) bc1 = 0;
    else if (scl && !scl_q) begin
      sh1 = {miso1, sh1[7:1]};
      bc1++;
      if (bc1 == 8) begin pop_chk("miso1", exp_miso1, sh1); bc1 = 0; end
    end
    scl_q = scl;
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic set_cs(input bit sel, input logic v);
    if (sel) cs1 = v;
    else     cs0 = v;
  endtask

  task automatic spi_begin(input bit sel);
    set_cs(sel, 1'b0);
    tick(8);
  endtask

  // One byte, 8 scl clocks of 8 clk; on the last byte cs rises before the final scl fall.
  task automatic spi_byte(input bit sel, input logic [7:0] b, input bit lsb, input bit last);
    for (int i = 0; i < 8; i++) begin
      mosi = lsb ? b[i] : b[7-i];
      tick(4);
      scl = 1'b1;
      if (i == 7 && last) begin
        tick(2);
        set_cs(sel, 1'b1);
        tick(2);
        scl = 1'b0;
      end else begin
        tick(4);
        scl = 1'b0;
      end
    end
  endtask

  int base_ovr, base_und, base_ferr;

  initial begin
    #1000000;
    $display("FAIL watchdog timeout checks=%0d", checks);
    $fatal(1);
  end

  initial begin
    rst = 1'b1; scl = 1'b0; mosi = 1'b0; cs0 = 1'b1; cs1 = 1'b1;
    rx_ready0 = 1'b0; rx_ready1 = 1'b1;
    tx_data0 = '0; tx_valid0 = 1'b0; tx_data1 = '0; tx_valid1 = 1'b0;
    tick(4);
    chk("rst_miso", miso0, 0);
    chk("rst_miso_oe", miso_oe0, 0);
    chk("rst_rx_data", rx_data0, 0);
    chk("rst_rx_valid", rx_valid0, 0);
    chk("rst_tx_ready", tx_ready0, 1);
    chk("rst_pulses", {rx_overrun0, tx_underrun0, frame_err0}, 0);
    rst = 1'b0;
    tick(8);

    // 0xA5 with TX empty: master reads 0xFF; byte held until rx_ready.
    base_und = n_und0;
    exp_rx0.push_back(8'hA5);
    exp_miso0.push_back(8'hFF);
    spi_begin(0);
    spi_byte(0, 8'hA5, 0, 1);
    tick(8);
    chk("t1_rx_valid", rx_valid0, 1);
    chk("t1_rx_data", rx_data0, 8'hA5);
    tick(20);
    chk("t1_rx_valid_held", rx_valid0, 1);
    chk("t1_underrun_cnt", n_und0 - base_und, 1);
    rx_ready0 = 1'b1;
    tick(1);
    chk("t1_rx_valid_clr", rx_valid0, 0);

    // 0x3C preloaded: tx_ready returns during LOAD.
    base_und = n_und0;
    tx_data0 = 8'h3C; tx_valid0 = 1'b1;
    tick(1);
    tx_valid0 = 1'b0;
    chk("t2_tx_ready_full", tx_ready0, 0);
    exp_rx0.push_back(8'h5A);
    exp_miso0.push_back(8'h3C);
    cs0 = 1'b0;
    tick(2);
    chk("t2_tx_ready_pre_load", tx_ready0, 0);
    tick(1);
    chk("t2_tx_ready_load", tx_ready0, 1);
    chk("t2_miso_oe", miso_oe0, 1);
    tick(5);
    spi_byte(0, 8'h5A, 0, 1);
    tick(8);
    chk("t2_underrun_cnt", n_und0 - base_und, 0);
    chk("t2_miso_oe_off", miso_oe0, 0);

    // 16-byte burst, both directions.
    base_ovr = n_ovr0; base_und = n_und0; base_ferr = n_ferr0;
    for (int i = 0; i < 16; i++) begin
      exp_rx0.push_back(8'(i));
      exp_miso0.push_back(8'hF0 + 8'(i));
    end
    fork
      begin
        for (int i = 0; i < 16; i++) begin
          int waitc;
          waitc = 0;
          tx_data0 = 8'hF0 + 8'(i);
          tx_valid0 = 1'b1;
          while (!tx_ready0 && waitc < 2000) begin
            tick(1);
            waitc++;
          end
          if (waitc >= 2000) begin
            chk("t3_tx_feed_timeout", 0, 1);
            break;
          end
          tick(1);
        end
        tx_valid0 = 1'b0;
      end
      begin
        tick(2);
        spi_begin(0);
        for (int i = 0; i < 16; i++) spi_byte(0, 8'(i), 0, i == 15);
        tick(8);
      end
    join
    chk("t3_overrun_cnt", n_ovr0 - base_ovr, 0);
    chk("t3_underrun_cnt", n_und0 - base_und, 0);
    chk("t3_frame_err_cnt", n_ferr0 - base_ferr, 0);

    // Overrun: 0x11 kept, 0x22 dropped.
    base_ovr = n_ovr0;
    rx_ready0 = 1'b0;
    exp_rx0.push_back(8'h11);
    exp_miso0.push_back(8'hFF);
    exp_miso0.push_back(8'hFF);
    spi_begin(0);
    spi_byte(0, 8'h11, 0, 0);
    spi_byte(0, 8'h22, 0, 1);
    tick(8);
    chk("t4_rx_data", rx_data0, 8'h11);
    chk("t4_overrun_cnt", n_ovr0 - base_ovr, 1);
    rx_ready0 = 1'b1;
    tick(2);
    chk("t4_rx_valid_clr", rx_valid0, 0);

    // Frame aborted after 5 bits, then a full byte 0x77.
    base_ferr = n_ferr0;
    spi_begin(0);
    for (int i = 0; i < 5; i++) begin
      mosi = 1'b1;
      tick(4);
      scl = 1'b1;
      tick(4);
      scl = 1'b0;
    end
    tick(4);
    cs0 = 1'b1;
    tick(8);
    chk("t5_frame_err_cnt", n_ferr0 - base_ferr, 1);
    exp_rx0.push_back(8'h77);
    exp_miso0.push_back(8'hFF);
    spi_begin(0);
    spi_byte(0, 8'h77, 0, 1);
    tick(8);
    chk("t5_frame_err_cnt_after", n_ferr0 - base_ferr, 1);

    // LSB-first instance.
    tx_data1 = 8'h80; tx_valid1 = 1'b1;
    tick(1);
    tx_valid1 = 1'b0;
    exp_rx1.push_back(8'h01);
    exp_miso1.push_back(8'h80);
    spi_begin(1);
    spi_byte(1, 8'h01, 1, 1);
    tick(8);
    chk("t6_tx_ready", tx_ready1, 1);
    chk("t6_miso_oe", miso_oe1, 0);
    chk("t6_pulse_cnt", n_ovr1 + n_und1 + n_ferr1, 0);

    tick(4);
    chk("end_rx0_queue", exp_rx0.size(), 0);
    chk("end_rx1_queue", exp_rx1.size(), 0);
    chk("end_miso0_queue", exp_miso0.size(), 0);
    chk("end_miso1_queue", exp_miso1.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
